// File: rtl/tt_um_hoene_manchester_encoder_if.sv
// Payload handshake and serial-line bundle for the Manchester encoder.
// The producer side (master) offers payloads and observes the line.
interface tt_um_hoene_manchester_encoder_if;
    logic [30:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        out;
    logic        out_busy;
    logic [5:0]  out_bit_index;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out,
        input  out_busy,
        input  out_bit_index
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out,
        output out_busy,
        output out_bit_index
    );
endinterface

// File: rtl/tt_um_hoene_manchester_encoder.sv
// Manchester encoder: low gap, then 31 payload bits MSB first plus
// an even-parity bit, each bit sent as two equal half-bit phases.
module tt_um_hoene_manchester_encoder #(
    parameter int HALF_BIT_CYCLES = 8,
    parameter int GAP_HALFBITS    = 4
) (
    input logic clk,
    input logic rst_n,
    tt_um_hoene_manchester_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        GAP,
        FIRST_HALF,
        SECOND_HALF
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(HALF_BIT_CYCLES - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_HALFBITS - 1);

    state_t      state;
    logic [5:0]  cnt;
    logic [3:0]  gap_cnt;
    logic [30:0] shreg;
    logic        parity;
    logic [5:0]  idx;
    logic        line;

    logic wrap;
    logic cur_bit;
    logic next_bit;

    assign wrap     = (cnt == CNT_LAST);
    // Bit 31 is the parity bit, not a shift-register bit.
    assign cur_bit  = (idx == 6'd31) ? parity : shreg[30];
    assign next_bit = (idx == 6'd30) ? parity : shreg[29];

    assign bus.in_ready      = (state == IDLE);
    assign bus.out_busy      = (state != IDLE);
    assign bus.out           = line;
    assign bus.out_bit_index = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            idx     <= '0;
            line    <= 1'b0;
        end else begin
            cnt <= (state == IDLE || wrap) ? 6'd0 : cnt + 6'd1;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state   <= GAP;
                        shreg   <= bus.in_data;
                        parity  <= ^bus.in_data;
                        gap_cnt <= '0;
                        idx     <= '0;
                        line    <= 1'b0;
                    end
                end
                GAP: begin
                    if (wrap) begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= FIRST_HALF;
                            line  <= ~shreg[30];
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                end
                FIRST_HALF: begin
                    if (wrap) begin
                        state <= SECOND_HALF;
                        line  <= cur_bit;
                    end
                end
                SECOND_HALF: begin
                    if (wrap) begin
                        if (idx == 6'd31) begin
                            state <= IDLE;
                            line  <= 1'b0;
                            idx   <= '0;
                        end else begin
                            state <= FIRST_HALF;
                            idx   <= idx + 6'd1;
                            shreg <= {shreg[29:0], 1'b0};
                            line  <= ~next_bit;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tt_um_hoene_manchester_encoder.sv
// Scoreboard bench: a frame-level waveform model predicts every cycle
// of the encoder outputs; a negedge monitor compares against the DUT.
module tb_tt_um_hoene_manchester_encoder;
    localparam int H = 8;
    localparam int G = 4;

    typedef struct packed {
        logic       o;
        logic       b;
        logic [5:0] i;
        logic       r;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tt_um_hoene_manchester_encoder_if bus ();

    tt_um_hoene_manchester_encoder #(
        .HALF_BIT_CYCLES(H),
        .GAP_HALFBITS(G)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    exp_t        expq[$];
    exp_t        wave[$];
    logic [30:0] payq[$];
    logic        last_busy = 1'b0;
    logic        random_on = 1'b0;
    int          cur_idx = 0;
    int          vectors = 0;
    int          miscompares = 0;

    localparam exp_t IDLE_EXP = '{o: 1'b0, b: 1'b0, i: 6'd0, r: 1'b1};

    // Whole-frame waveform from the frame rules: gap, then 32 bits.
    function automatic void build(input logic [30:0] d);
        logic [31:0] f;
        logic        bv;
        f = {d, ^d};
        for (int g = 0; g < G * H; g++)
            wave.push_back('{o: 1'b0, b: 1'b1, i: 6'd0, r: 1'b0});
        for (int k = 0; k < 32; k++) begin
            bv = f[31-k];
            for (int c = 0; c < H; c++)
                wave.push_back('{o: ~bv, b: 1'b1, i: 6'(k), r: 1'b0});
            for (int c = 0; c < H; c++)
                wave.push_back('{o: bv, b: 1'b1, i: 6'(k), r: 1'b0});
        end
    endfunction

    task automatic chk(input string n, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, req);
        end
    endtask

    task automatic drive_inputs();
        if (payq.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = payq[0];
        end else begin
            bus.in_valid = random_on && ($urandom_range(0, 15) == 0);
            bus.in_data  = 31'($urandom);
        end
    endtask

    // One clock: model the edge, push the expectation, drive new inputs.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        if (!rst_n) begin
            e = IDLE_EXP;
        end else begin
            if (!last_busy && bus.in_valid) begin
                build(bus.in_data);
                if (payq.size() > 0) void'(payq.pop_front());
            end
            e = (wave.size() > 0) ? wave.pop_front() : IDLE_EXP;
        end
        last_busy = e.b;
        cur_idx   = int'(e.i);
        expq.push_back(e);
        #1;
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out"}, int'(bus.out), 0);
        chk({tag, "_busy"}, int'(bus.out_busy), 0);
        chk({tag, "_idx"}, int'(bus.out_bit_index), 0);
        chk({tag, "_ready"}, int'(bus.in_ready), 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("out", int'(bus.out), int'(e.o));
            chk("busy", int'(bus.out_busy), int'(e.b));
            chk("bit_index", int'(bus.out_bit_index), int'(e.i));
            chk("ready", int'(bus.in_ready), int'(e.r));
        end
    end

    initial begin
        int   waited;
        logic hit;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #2;
        check_reset_state("reset_hold");
        run(3);
        rst_n = 1'b1;

        payq.push_back(31'h0000_0000);
        payq.push_back(31'h0000_0001);
        payq.push_back(31'h7FFF_FFFF);
        payq.push_back(31'($urandom));
        payq.push_back(31'($urandom));
        drive_inputs();
        run(5 * 546 + 20);

        random_on = 1'b1;
        run(3000);
        random_on = 1'b0;
        run(600);

        payq.push_back(31'($urandom));
        hit = 1'b0;
        waited = 0;
        while (!hit && waited < 2000) begin
            cycle();
            waited++;
            if (last_busy && cur_idx == 10) hit = 1'b1;
        end
        if (!hit) begin
            miscompares++;
            $display("FAIL bit10_timeout: got no bit 10 expected bit 10");
        end
        run(4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_async");
        wave.delete();
        last_busy = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(60);

        payq.push_back(31'($urandom));
        drive_inputs();
        run(600);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tt_um_hoene_manchester_encoder.md
TT_UM_HOENE_MANCHESTER_ENCODER -- requirements
Module: tt_um_hoene_manchester_encoder

Interface
REQ-001 Parameter HALF_BIT_CYCLES, default 8, clk cycles per Manchester half-bit; legal range 2..63.
REQ-002 Parameter GAP_HALFBITS, default 4, half-bits of forced-low line before each frame; legal range 2..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  31  frame payload, sampled only on acceptance.
REQ-006 in_valid  input  1  payload offered.
REQ-007 in_ready  output  1  encoder can accept a payload this cycle.
REQ-008 out  output  1  Manchester-encoded serial line, registered.
REQ-009 out_busy  output  1  frame (gap or bits) in progress.
REQ-010 out_bit_index  output  6  index of bit being sent, 0..31; 0 when not sending bits.

Function
REQ-011 Acceptance occurs on a rising edge where in_valid=1 and in_ready=1; in_data is latched in a 31-bit shift register at that edge.
REQ-012 in_ready = 1 only in state IDLE; in_valid while not IDLE is ignored, with no latch and no queuing.
REQ-013 States: IDLE -> GAP (on acceptance) -> FIRST_HALF <-> SECOND_HALF -> IDLE.
REQ-014 GAP lasts exactly GAP_HALFBITS*HALF_BIT_CYCLES cycles; out=0 throughout.
REQ-015 Frame = 32 bits: in_data[30] first down to in_data[0], then parity bit = XOR of in_data[30:0] (even parity over all 32 bits).
REQ-016 Encoding: bit 1 = out 0 for first half, 1 for second half; bit 0 = out 1 for first half, 0 for second half; each half lasts exactly HALF_BIT_CYCLES cycles.
REQ-017 A half-bit counter (6 bits) counts 0..HALF_BIT_CYCLES-1 and wraps; the state advances on the wrap.
REQ-018 out_bit_index increments after each SECOND_HALF wrap; after bit 31's SECOND_HALF, go to IDLE (no bit 32).
REQ-019 out is registered: the value for a half-bit appears on the first cycle of that half-bit and holds for HALF_BIT_CYCLES cycles.
REQ-020 Timing with acceptance at edge E: out forced 0 for cycles E+1..E+G*H; bit k first half starts at E+G*H+1+2kH; IDLE (in_ready=1, out=0) from E+(G+64)*H+1. G=GAP_HALFBITS, H=HALF_BIT_CYCLES.
REQ-021 In IDLE, out=0 (idle line low); a trailing high second half returns to 0 on entry to IDLE.
REQ-022 out_busy=1 in GAP, FIRST_HALF and SECOND_HALF; otherwise 0.
REQ-023 Back-to-back: if in_valid is held high, the next frame is accepted on the first IDLE cycle, then a full GAP is sent; frames never overlap and GAP is never skipped.
REQ-024 Payload changes on in_data after acceptance have no effect on the frame in flight.

Reset
REQ-025 rst_n=0 asynchronously forces: state IDLE, out=0, out_busy=0, in_ready=1, out_bit_index=0, counters and shift register 0.
REQ-026 Reset mid-frame aborts the frame immediately; after release, no partial frame resumes; the next frame needs a fresh acceptance.
REQ-027 The first rising edge after rst_n deasserts may accept a payload.

Verification (H=8, G=4)
REQ-028 Reset: hold rst_n=0 -> out=0, in_ready=1, out_busy=0, out_bit_index=0; assert rst_n low asynchronously between edges -> outputs change without a clock edge.
REQ-029 in_data=31'h0000_0000 -> 32 cycles low, then 32 x (8 cycles high, 8 cycles low), parity 0; in_ready returns 1 at cycle 545 after acceptance.
REQ-030 in_data=31'h0000_0001 -> bits 30..1 encode as 0, bit 0 as low8/high8, parity bit 1 as low8/high8, then out=0.
REQ-031 in_data=31'h7FFF_FFFF -> 31 ones plus parity 1 -> 32 x (low8, high8); out_bit_index steps 0..31 every 16 cycles.
REQ-032 Hold in_valid=1 with two payloads -> second acceptance exactly on the first in_ready=1 cycle, then 32-cycle low GAP; a toggle of in_valid while busy causes no acceptance.
REQ-033 Pulse rst_n low during bit 10 of a frame -> out=0 immediately, IDLE, no further transitions until a new acceptance.
